// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY blocks.
//   - 64b/66b sync header values
//   - error-injector mode encodings and forced-corruption mask
//   - error-injector FSM state type
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_RANDOM = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_SINGLE = 2'b11;

  // Flipping bit 0 maps 01->00 and 10->11, so a forced error is always an
  // invalid header rather than a silently wrong but legal one.
  localparam logic [1:0] FORCE_MASK = 2'b01;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_INJECT = 1'b1
  } inj_state_e;

endpackage

// File: rtl/eth_phy_10g_prbs31_step.sv
// Combinational parallel PRBS31 (x^31 + x^28 + 1) advancer.
// Ports:
//   state_in  : current 31-bit LFSR state
//   state_out : state after STEPS serial shifts
// Each serial shift is state <= {state[29:0], state[30] ^ state[27]}.
module eth_phy_10g_prbs31_step #(
  parameter int STEPS = 32
) (
  input  logic [30:0] state_in,
  output logic [30:0] state_out
);

  logic [30:0] s;

  always_comb begin
    s = state_in;
    for (int i = 0; i < STEPS; i++) begin
      s = {s[29:0], s[30] ^ s[27]};
    end
    state_out = s;
  end

endmodule

// File: rtl/eth_phy_10g_tx_hdr_err_inj.sv
// TX sync-header error injector between the 64b/66b encoder and the SERDES.
// One register stage; the payload is passed through untouched while the
// 2-bit sync header may be corrupted randomly, in a triggered burst, or as a
// single shot. Saturating block and error counters are kept.
// Ports:
//   tx_clk, tx_rst_n            : block clock, async active-low reset
//   in_data/in_hdr/in_valid     : block from encoder
//   out_data/out_hdr/out_valid  : block to SERDES, 1 cycle later
//   cfg_enable/cfg_mode         : master enable, off/random/burst/single
//   cfg_threshold               : random-mode per-bit flip threshold
//   cfg_burst_len/cfg_trigger   : burst length and start pulse
//   cfg_err_clear               : synchronous counter clear
//   status_busy                 : burst or single shot in progress
//   status_block_count/err_count: saturating counters
// Only HDR_WIDTH = 2 is supported. THRESH_WIDTH must be <= 15 so that both
// random draws fit in the 31-bit LFSR.
module eth_phy_10g_tx_hdr_err_inj
  import eth_phy_10g_pkg::*;
#(
  parameter int          DATA_WIDTH   = 64,
  parameter int          HDR_WIDTH    = 2,
  parameter int          THRESH_WIDTH = 10,
  parameter logic [30:0] LFSR_SEED    = 31'h7FFFFFFF,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [HDR_WIDTH-1:0]    in_hdr,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [HDR_WIDTH-1:0]    out_hdr,
  output logic                    out_valid,
  input  logic                    cfg_enable,
  input  logic [1:0]              cfg_mode,
  input  logic [THRESH_WIDTH-1:0] cfg_threshold,
  input  logic [5:0]              cfg_burst_len,
  input  logic                    cfg_trigger,
  input  logic                    cfg_err_clear,
  output logic                    status_busy,
  output logic [CNT_WIDTH-1:0]    status_block_count,
  output logic [CNT_WIDTH-1:0]    status_err_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  inj_state_e             state_q, state_d;
  logic [5:0]             rem_q, rem_d, eff_rem;
  logic                   start, eff_inject, force_hdr;
  logic [30:0]            lfsr_q, lfsr_next;
  logic [THRESH_WIDTH-1:0] r0, r1;
  logic [HDR_WIDTH-1:0]   flip, hdr_d;

  eth_phy_10g_prbs31_step #(.STEPS(32)) u_prbs (
    .state_in  (lfsr_q),
    .state_out (lfsr_next)
  );

  assign r0 = lfsr_q[THRESH_WIDTH-1:0];
  assign r1 = lfsr_q[2*THRESH_WIDTH-1:THRESH_WIDTH];

  // eff_inject/eff_rem describe the cycle as if a trigger had already moved
  // the FSM into INJECT, so a trigger on a valid cycle corrupts that block.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    eff_inject = 1'b0;
    eff_rem    = rem_q;
    force_hdr  = 1'b0;
    start      = cfg_trigger && cfg_enable &&
                 ((cfg_mode == MODE_BURST && cfg_burst_len != 6'd0) ||
                  cfg_mode == MODE_SINGLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          eff_inject = 1'b1;
          eff_rem    = (cfg_mode == MODE_SINGLE) ? 6'd1 : cfg_burst_len;
        end
      end
      ST_INJECT: begin
        // Dropping enable aborts at once; triggers here are not queued.
        if (cfg_enable) begin
          eff_inject = 1'b1;
        end else begin
          state_d = ST_IDLE;
          rem_d   = 6'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 6'd0;
      end
    endcase
    if (eff_inject) begin
      if (in_valid) begin
        force_hdr = 1'b1;
        if (eff_rem == 6'd1) begin
          state_d = ST_IDLE;
          rem_d   = 6'd0;
        end else begin
          state_d = ST_INJECT;
          rem_d   = eff_rem - 6'd1;
        end
      end else begin
        state_d = ST_INJECT;
        rem_d   = eff_rem;
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= 6'd0;
      status_busy <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      status_busy <= eff_inject;
    end
  end

  // Forced corruption wins over random flips if the mode is switched to
  // random in the middle of a burst.
  always_comb begin
    flip = '0;
    if (force_hdr) begin
      flip = FORCE_MASK;
    end else if (in_valid && cfg_enable && cfg_mode == MODE_RANDOM) begin
      flip[0] = (r0 < cfg_threshold);
      flip[1] = (r1 < cfg_threshold);
    end
    hdr_d = in_hdr ^ flip;
  end

  // ---- output register stage ----
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      out_data  <= '0;
      out_hdr   <= '0;
      out_valid <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      out_data  <= in_data;
      out_hdr   <= hdr_d;
      out_valid <= in_valid;
      if (in_valid) begin
        lfsr_q <= lfsr_next;
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      status_block_count <= '0;
      status_err_count   <= '0;
    end else if (cfg_err_clear) begin
      status_block_count <= '0;
      status_err_count   <= '0;
    end else if (in_valid) begin
      if (status_block_count != CNT_MAX) begin
        status_block_count <= status_block_count + 1'b1;
      end
      if (hdr_d != in_hdr && status_err_count != CNT_MAX) begin
        status_err_count <= status_err_count + 1'b1;
      end
    end
  end

endmodule
